// File: rtl/anim_timer_pkg.sv
// Shared types and defaults for the animation timer block.
// Holds the channel state encoding and default sizing constants.
package anim_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  localparam int DEF_WIDTH    = 20;
  localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/anim_timer_chan.sv
// One animation timer channel: IDLE/RUN FSM, up-counter to a latched limit.
// Ports: Clk, Reset_n, tick_en, start, stop, periodic, limit -> count, busy, done.
module anim_timer_chan
  import anim_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             tick_en,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  chan_state_t      state;
  logic [WIDTH-1:0] lim;
  logic             per;

  // state is a flop, so busy is a registered output
  assign busy = (state == RUN);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      count <= '0;
      lim   <= '0;
      per   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      // stop beats start; start (restart) beats the terminal event
      if (stop) begin
        state <= IDLE;
      end else if (start) begin
        state <= RUN;
        count <= '0;
        lim   <= limit;
        per   <= periodic;
      end else if (state == RUN && tick_en) begin
        if (count == lim) begin
          done <= 1'b1;
          if (per) count <= '0;
          else     state <= IDLE;
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/anim_timer.sv
// Multi-channel animation timer: CHANNELS independent one-shot/periodic counters.
// Ports: Clk, Reset_n, tick_en, start/stop/periodic, limit[] -> count[], busy, done.
module anim_timer
  import anim_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      tick_en,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*WIDTH-1:0] limit,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    anim_timer_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .tick_en (tick_en),
      .start   (start[i]),
      .stop    (stop[i]),
      .periodic(periodic[i]),
      .limit   (limit[i*WIDTH +: WIDTH]),
      .count   (count[i*WIDTH +: WIDTH]),
      .busy    (busy[i]),
      .done    (done[i])
    );
  end

endmodule

// File: tb/tb_anim_timer.sv
// Directed self-checking bench for anim_timer.
// Main 4x20-bit instance plus a 1x8-bit instance for the all-ones limit.
module tb_anim_timer;

  localparam int W  = 20;
  localparam int N  = 4;
  localparam int WS = 8;

  logic         Clk;
  logic         Reset_n;
  logic         tick_en;
  logic [N-1:0] start;
  logic [N-1:0] stop;
  logic [N-1:0] periodic;
  logic [N*W-1:0] limit;
  logic [N*W-1:0] count;
  logic [N-1:0] busy;
  logic [N-1:0] done;

  logic          tick_en_s;
  logic [0:0]    start_s;
  logic [0:0]    stop_s;
  logic [0:0]    periodic_s;
  logic [WS-1:0] limit_s;
  logic [WS-1:0] count_s;
  logic [0:0]    busy_s;
  logic [0:0]    done_s;

  int checks = 0;
  int errors = 0;

  anim_timer #(.WIDTH(W), .CHANNELS(N)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .tick_en (tick_en),
    .start   (start),
    .stop    (stop),
    .periodic(periodic),
    .limit   (limit),
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

  anim_timer #(.WIDTH(WS), .CHANNELS(1)) dut_s (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .tick_en (tick_en_s),
    .start   (start_s),
    .stop    (stop_s),
    .periodic(periodic_s),
    .limit   (limit_s),
    .count   (count_s),
    .busy    (busy_s),
    .done    (done_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] cnt(input int c);
    return count[c*W +: W];
  endfunction

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    tick_en = 1'b0;
    start = '0;
    stop = '0;
    periodic = '0;
    limit = '0;
    tick_en_s = 1'b0;
    start_s = '0;
    stop_s = '0;
    periodic_s = '0;
    limit_s = '0;
    #1;
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL reset_count got %h want 0", count);
    end
    checks++;
    if (busy !== '0 || done !== '0) begin
      errors++;
      $display("FAIL reset_flags busy %b done %b want 0", busy, done);
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
    checks++;
    if (busy !== '0 || done !== '0 || count !== '0) begin
      errors++;
      $display("FAIL post_reset busy %b done %b count %h", busy, done, count);
    end
  endtask

  task automatic test_one_shot;
    limit[0*W +: W] = W'(5);
    periodic[0] = 1'b0;
    tick_en = 1'b1;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1 || cnt(0) !== W'(0)) begin
      errors++;
      $display("FAIL os_start busy %b count %0d want 1/0", busy[0], cnt(0));
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (cnt(0) !== W'(i) || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL os_count got %0d done %b want %0d", cnt(0), done[0], i);
      end
    end
    step();
    checks++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0 || cnt(0) !== W'(5)) begin
      errors++;
      $display("FAIL os_term done %b busy %b count %0d want 1/0/5",
               done[0], busy[0], cnt(0));
    end
    step();
    checks++;
    if (done[0] !== 1'b0 || cnt(0) !== W'(5)) begin
      errors++;
      $display("FAIL os_after done %b count %0d want 0/5", done[0], cnt(0));
    end
  endtask

  task automatic test_periodic;
    int exp_cnt [16];
    exp_cnt = '{1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    limit[1*W +: W] = W'(3);
    periodic[1] = 1'b1;
    tick_en = 1'b0;
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    for (int s = 1; s <= 16; s++) begin
      tick_en = s[0];
      step();
      checks++;
      if (cnt(1) !== W'(exp_cnt[s-1]) || busy[1] !== 1'b1 ||
          done[1] !== ((s == 7) || (s == 15))) begin
        errors++;
        $display("FAIL per_step%0d count %0d busy %b done %b want %0d",
                 s, cnt(1), busy[1], done[1], exp_cnt[s-1]);
      end
    end
    tick_en = 1'b1;
  endtask

  task automatic test_collision;
    limit[2*W +: W] = W'(20);
    periodic[2] = 1'b0;
    tick_en = 1'b1;
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    repeat (7) step();
    tick_en = 1'b0;
    step();
    checks++;
    if (cnt(2) !== W'(7) || busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL col_hold count %0d busy %b want 7/1", cnt(2), busy[2]);
    end
    stop[2] = 1'b1;
    start[2] = 1'b1;
    step();
    stop[2] = 1'b0;
    start[2] = 1'b0;
    checks++;
    if (busy[2] !== 1'b0 || cnt(2) !== W'(7) || done[2] !== 1'b0) begin
      errors++;
      $display("FAIL col_stop busy %b count %0d done %b want 0/7/0",
               busy[2], cnt(2), done[2]);
    end
    tick_en = 1'b1;
    step();
    checks++;
    if (busy[2] !== 1'b0 || cnt(2) !== W'(7) || done[2] !== 1'b0) begin
      errors++;
      $display("FAIL col_idle busy %b count %0d done %b want 0/7/0",
               busy[2], cnt(2), done[2]);
    end
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    repeat (7) step();
    limit[2*W +: W] = W'(2);
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    checks++;
    if (busy[2] !== 1'b1 || cnt(2) !== W'(0) || done[2] !== 1'b0) begin
      errors++;
      $display("FAIL col_restart busy %b count %0d done %b want 1/0/0",
               busy[2], cnt(2), done[2]);
    end
    limit[2*W +: W] = W'(9);
    step();
    step();
    step();
    checks++;
    if (done[2] !== 1'b1 || busy[2] !== 1'b0 || cnt(2) !== W'(2)) begin
      errors++;
      $display("FAIL col_latched done %b busy %b count %0d want 1/0/2",
               done[2], busy[2], cnt(2));
    end
    limit[2*W +: W] = W'(2);
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    step();
    step();
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    checks++;
    if (done[2] !== 1'b0 || cnt(2) !== W'(0) || busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL col_term_start done %b count %0d busy %b want 0/0/1",
               done[2], cnt(2), busy[2]);
    end
    step();
    checks++;
    if (done[2] !== 1'b0 || cnt(2) !== W'(1)) begin
      errors++;
      $display("FAIL col_term_next done %b count %0d want 0/1",
               done[2], cnt(2));
    end
    stop[2] = 1'b1;
    step();
    stop[2] = 1'b0;
    checks++;
    if (busy[2] !== 1'b0 || done[2] !== 1'b0 || cnt(2) !== W'(1)) begin
      errors++;
      $display("FAIL col_stop_only busy %b done %b count %0d want 0/0/1",
               busy[2], done[2], cnt(2));
    end
  endtask

  task automatic test_limit_zero;
    limit[3*W +: W] = W'(0);
    periodic[3] = 1'b0;
    tick_en = 1'b0;
    start[3] = 1'b1;
    step();
    start[3] = 1'b0;
    step();
    checks++;
    if (done[3] !== 1'b0 || busy[3] !== 1'b1) begin
      errors++;
      $display("FAIL lz_wait done %b busy %b want 0/1", done[3], busy[3]);
    end
    tick_en = 1'b1;
    step();
    checks++;
    if (done[3] !== 1'b1 || busy[3] !== 1'b0 || cnt(3) !== W'(0)) begin
      errors++;
      $display("FAIL lz_done done %b busy %b count %0d want 1/0/0",
               done[3], busy[3], cnt(3));
    end
  endtask

  task automatic test_max_limit;
    limit_s = '1;
    periodic_s = 1'b0;
    tick_en_s = 1'b1;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    repeat (255) step();
    checks++;
    if (count_s !== 8'hFF || busy_s !== 1'b1 || done_s !== 1'b0) begin
      errors++;
      $display("FAIL max_near count %h busy %b done %b want ff/1/0",
               count_s, busy_s, done_s);
    end
    step();
    checks++;
    if (count_s !== 8'hFF || busy_s !== 1'b0 || done_s !== 1'b1) begin
      errors++;
      $display("FAIL max_term count %h busy %b done %b want ff/0/1",
               count_s, busy_s, done_s);
    end
    step();
    step();
    checks++;
    if (count_s !== 8'hFF || done_s !== 1'b0) begin
      errors++;
      $display("FAIL max_hold count %h done %b want ff/0", count_s, done_s);
    end
  endtask

  task automatic test_independence;
    for (int c = 0; c < N; c++) limit[c*W +: W] = W'(c + 1);
    periodic = '1;
    tick_en = 1'b1;
    start = '1;
    step();
    start = '0;
    for (int s = 1; s <= 20; s++) begin
      step();
      for (int c = 0; c < N; c++) begin
        checks++;
        if (done[c] !== ((s % (c + 2)) == 0)) begin
          errors++;
          $display("FAIL ind_ch%0d_step%0d done %b", c, s, done[c]);
        end
      end
    end
    checks++;
    if (busy !== 4'hF) begin
      errors++;
      $display("FAIL ind_busy got %b want 1111", busy);
    end
  endtask

  task automatic test_async_reset;
    for (int c = 0; c < N; c++) limit[c*W +: W] = W'(10);
    periodic = '1;
    tick_en = 1'b1;
    start = '1;
    step();
    start = '0;
    repeat (4) step();
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (count !== '0 || busy !== '0 || done !== '0) begin
      errors++;
      $display("FAIL ar_now count %h busy %b done %b want 0",
               count, busy, done);
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int s = 0; s < 12; s++) begin
      step();
      checks++;
      if (done !== '0 || busy !== '0 || count !== '0) begin
        errors++;
        $display("FAIL ar_after%0d done %b busy %b count %h",
                 s, done, busy, count);
      end
    end
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    checks++;
    if (busy !== 4'b0001 || cnt(0) !== W'(0)) begin
      errors++;
      $display("FAIL ar_restart busy %b count %0d want 0001/0", busy, cnt(0));
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_collision();
    test_limit_zero();
    test_max_limit();
    test_independence();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
